multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/mccu_pkg.sv | 13 +
 rtl/mccu_decode.sv | 30 +++
 rtl/multicycle_control_unit.sv | 102 ++++++++++
 tb/tb_multicycle_control_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mccu_pkg.sv
// mccu_pkg: shared state encoding, opcode and alu_op constants for the multicycle control unit.
package mccu_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;
  localparam int OP_R = 0, OP_ADDI = 1, OP_ORI = 2, OP_ANDI = 3, OP_LW = 4;
  localparam int OP_SW = 5, OP_BEQ = 6, OP_BGT = 7, OP_J = 8;
  localparam int ALU_AND = 0, ALU_OR = 1, ALU_ADD = 2, ALU_SUB = 3, ALU_FUNCT = 4;
endpackage

// File: rtl/mccu_decode.sv
// mccu_decode: combinational op -> steering/alu_op table plus legality flag.
module mccu_decode
  import mccu_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic [OPW-1:0]    op,
  output logic              regDst,
  output logic              aluSrc,
  output logic              memToReg,
  output logic              extOp,
  output logic              legal,
  output logic [ALUOPW-1:0] aluOp
);
  logic isAdd, isSub;
  always_comb begin
    isAdd    = op == OPW'(OP_ADDI) || op == OPW'(OP_LW) || op == OPW'(OP_SW);
    isSub    = op == OPW'(OP_BEQ) || op == OPW'(OP_BGT);
    regDst   = op == OPW'(OP_R);
    aluSrc   = op >= OPW'(OP_ADDI) && op <= OPW'(OP_SW);
    memToReg = op == OPW'(OP_LW);
    extOp    = op == OPW'(OP_LW) || op == OPW'(OP_SW) || isSub;
    legal    = op <= OPW'(OP_J);
    aluOp    = regDst               ? ALUOPW'(ALU_FUNCT) :
               isAdd                ? ALUOPW'(ALU_ADD)   :
               op == OPW'(OP_ORI)   ? ALUOPW'(ALU_OR)    :
               isSub                ? ALUOPW'(ALU_SUB)   : ALUOPW'(ALU_AND);
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle datapath with a retired-instruction counter.
// Define MCCU_MEM_WAIT_EN to add mem_ready and stretch MEM until memory completes.
module multicycle_control_unit
  import mccu_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [OPW-1:0]    opcode,
`ifdef MCCU_MEM_WAIT_EN
  input  logic              mem_ready,
`endif
  output logic              pc_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch_eq,
  output logic              branch_gr,
  output logic              jump,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              ext_op,
  output logic [ALUOPW-1:0] alu_op,
  output logic [2:0]        state,
  output logic              illegal,
  output logic [CNTW-1:0]   retired
);
  state_t cur, nxt;
  logic [OPW-1:0] op;
  logic [ALUOPW-1:0] aluOp;
  logic regDst, aluSrc, memToReg, extOp, legal;
  logic memDone, retire, go, isLw, isMem, isCtl;
  mccu_decode #(.OPW(OPW), .ALUOPW(ALUOPW)) decode (
    .op(op), .regDst(regDst), .aluSrc(aluSrc), .memToReg(memToReg),
    .extOp(extOp), .legal(legal), .aluOp(aluOp)
  );
`ifdef MCCU_MEM_WAIT_EN
  assign memDone = mem_ready;
`else
  assign memDone = 1'b1;
`endif
  assign isLw  = op == OPW'(OP_LW);
  assign isMem = isLw || op == OPW'(OP_SW);
  assign isCtl = op == OPW'(OP_BEQ) || op == OPW'(OP_BGT) || op == OPW'(OP_J);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur     <= FETCH;
      op      <= '0;
      retired <= '0;
    end else if (en) begin
      cur <= nxt;
      if (cur == FETCH) op <= opcode;
      if (retire) retired <= retired + CNTW'(1);
    end
  // retire marks the last cycle of a legal instruction
  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: nxt = legal ? EXEC : FETCH;
      EXEC: begin
        nxt    = isMem ? MEM : isCtl ? FETCH : WB;
        retire = isCtl;
      end
      MEM: begin
        nxt    = !memDone ? MEM : isLw ? WB : FETCH;
        retire = memDone && !isLw;
      end
      WB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  // strobes are gated by en and rst; steering follows the latched op only
  always_comb begin
    go         = en && !rst;
    pc_write   = go && cur == FETCH;
    ir_write   = go && cur == FETCH;
    reg_write  = go && cur == WB;
    mem_read   = go && cur == MEM && isLw;
    mem_write  = go && cur == MEM && op == OPW'(OP_SW);
    branch_eq  = go && cur == EXEC && op == OPW'(OP_BEQ);
    branch_gr  = go && cur == EXEC && op == OPW'(OP_BGT);
    jump       = go && cur == EXEC && op == OPW'(OP_J);
    illegal    = go && cur == DECODE && !legal;
    reg_dst    = cur != FETCH && regDst;
    alu_src    = cur != FETCH && aluSrc;
    mem_to_reg = cur != FETCH && memToReg;
    ext_op     = cur != FETCH && extOp;
    alu_op     = cur == FETCH ? '0 : aluOp;
    state      = cur;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed table, corner sequences and random run against a path-queue reference model.
module tb_multicycle_control_unit;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = '0;
  wire [18:0] o1, o2;
  wire [15:0] retired;
  wire [1:0]  retired2;
  int nTests = 0, nFail = 0;
  int mState = 0, mOp = 0, mRet = 0;
  int path[$];
  logic [3:0] steerT [9] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0111, 4'b0101, 4'b0001, 4'b0001, 4'b0000};
  logic [2:0] aluT [9] = '{3'd4, 3'd2, 3'd1, 3'd0, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
  typedef struct {
    logic r, e;
    logic [5:0] op;
    logic [2:0] st;
    logic [7:0] stb;
    logic [3:0] sr;
    logic [2:0] al;
    logic il;
    int ret;
  } vec_t;
  vec_t tbl [26];
  int retSeq [5] = '{1, 2, 3, 0, 1};
  always #5 clk = ~clk;
  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
`ifdef MCCU_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(o1[18]), .ir_write(o1[17]), .reg_write(o1[16]), .mem_read(o1[15]),
    .mem_write(o1[14]), .branch_eq(o1[13]), .branch_gr(o1[12]), .jump(o1[11]),
    .reg_dst(o1[10]), .alu_src(o1[9]), .mem_to_reg(o1[8]), .ext_op(o1[7]),
    .alu_op(o1[6:4]), .state(o1[3:1]), .illegal(o1[0]), .retired(retired)
  );
  multicycle_control_unit #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
`ifdef MCCU_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(o2[18]), .ir_write(o2[17]), .reg_write(o2[16]), .mem_read(o2[15]),
    .mem_write(o2[14]), .branch_eq(o2[13]), .branch_gr(o2[12]), .jump(o2[11]),
    .reg_dst(o2[10]), .alu_src(o2[9]), .mem_to_reg(o2[8]), .ext_op(o2[7]),
    .alu_op(o2[6:4]), .state(o2[3:1]), .illegal(o2[0]), .retired(retired2)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [18:0] expOut();
    logic go, lg;
    logic [7:0] st;
    logic [3:0] sr;
    logic [2:0] al;
    go = en && !rst;
    lg = mOp <= 8;
    st = {go && mState == 0, go && mState == 0, go && mState == 4,
          go && mState == 3 && mOp == 4, go && mState == 3 && mOp == 5,
          go && mState == 2 && mOp == 6, go && mState == 2 && mOp == 7, go && mState == 2 && mOp == 8};
    sr = (mState == 0 || !lg) ? 4'b0 : steerT[mOp];
    al = (mState == 0 || !lg) ? 3'd0 : aluT[mOp];
    return {st, sr, al, 3'(mState), go && mState == 1 && !lg};
  endfunction
  // an instruction is the list of states it visits after FETCH; it retires when the list runs out
  task automatic modelStep();
    logic mrEff;
`ifdef MCCU_MEM_WAIT_EN
    mrEff = mem_ready;
`else
    mrEff = 1'b1;
`endif
    if (mState == 0) begin
      mOp = int'(opcode);
      if (mOp <= 3) path = '{1, 2, 4};
      else if (mOp == 4) path = '{1, 2, 3, 4};
      else if (mOp == 5) path = '{1, 2, 3};
      else if (mOp <= 8) path = '{1, 2};
      else path = '{1};
      mState = path.pop_front();
    end else if (mState == 3 && !mrEff) begin
    end else if (path.size() == 0) begin
      if (mOp <= 8) mRet++;
      mState = 0;
    end else mState = path.pop_front();
  endtask
  task automatic drive(input logic r, input logic e, input logic [5:0] op, input logic mr);
    rst = r; en = e; opcode = op; mem_ready = mr;
    if (r) begin
      mState = 0; mOp = 0; mRet = 0;
      path.delete();
    end
    #1;
    chk("model_out", 32'(o1), 32'(expOut()));
    chk("model_out_cnt2", 32'(o2), 32'(expOut()));
    chk("model_retired", 32'(retired), mRet % 65536);
    chk("model_retired_cnt2", 32'(retired2), mRet % 4);
  endtask
  task automatic adv();
    @(posedge clk);
    if (!rst && en) modelStep();
    @(negedge clk);
  endtask
  initial begin
    tbl = '{
      '{1'b1, 1'b1, 6'd0, 3'd0, 8'h00, 4'h0, 3'd0, 1'b0, 0},
      '{1'b0, 1'b1, 6'd0, 3'd0, 8'hC0, 4'h0, 3'd0, 1'b0, 0},
      '{1'b0, 1'b1, 6'd0, 3'd1, 8'h00, 4'h8, 3'd4, 1'b0, 0},
      '{1'b0, 1'b1, 6'd0, 3'd2, 8'h00, 4'h8, 3'd4, 1'b0, 0},
      '{1'b0, 1'b1, 6'd0, 3'd4, 8'h20, 4'h8, 3'd4, 1'b0, 0},
      '{1'b0, 1'b1, 6'd4, 3'd0, 8'hC0, 4'h0, 3'd0, 1'b0, 1},
      '{1'b0, 1'b1, 6'd4, 3'd1, 8'h00, 4'h7, 3'd2, 1'b0, 1},
      '{1'b0, 1'b1, 6'd4, 3'd2, 8'h00, 4'h7, 3'd2, 1'b0, 1},
      '{1'b0, 1'b1, 6'd4, 3'd3, 8'h10, 4'h7, 3'd2, 1'b0, 1},
      '{1'b0, 1'b1, 6'd4, 3'd4, 8'h20, 4'h7, 3'd2, 1'b0, 1},
      '{1'b0, 1'b1, 6'd5, 3'd0, 8'hC0, 4'h0, 3'd0, 1'b0, 2},
      '{1'b0, 1'b1, 6'd5, 3'd1, 8'h00, 4'h5, 3'd2, 1'b0, 2},
      '{1'b0, 1'b1, 6'd5, 3'd2, 8'h00, 4'h5, 3'd2, 1'b0, 2},
      '{1'b0, 1'b1, 6'd5, 3'd3, 8'h08, 4'h5, 3'd2, 1'b0, 2},
      '{1'b0, 1'b1, 6'd9, 3'd0, 8'hC0, 4'h0, 3'd0, 1'b0, 3},
      '{1'b0, 1'b1, 6'd9, 3'd1, 8'h00, 4'h0, 3'd0, 1'b1, 3},
      '{1'b0, 1'b1, 6'd8, 3'd0, 8'hC0, 4'h0, 3'd0, 1'b0, 3},
      '{1'b0, 1'b1, 6'd8, 3'd1, 8'h00, 4'h0, 3'd0, 1'b0, 3},
      '{1'b0, 1'b1, 6'd8, 3'd2, 8'h01, 4'h0, 3'd0, 1'b0, 3},
      '{1'b0, 1'b1, 6'd6, 3'd0, 8'hC0, 4'h0, 3'd0, 1'b0, 4},
      '{1'b0, 1'b1, 6'd6, 3'd1, 8'h00, 4'h1, 3'd3, 1'b0, 4},
      '{1'b0, 1'b0, 6'd6, 3'd2, 8'h00, 4'h1, 3'd3, 1'b0, 4},
      '{1'b0, 1'b0, 6'd6, 3'd2, 8'h00, 4'h1, 3'd3, 1'b0, 4},
      '{1'b0, 1'b0, 6'd6, 3'd2, 8'h00, 4'h1, 3'd3, 1'b0, 4},
      '{1'b0, 1'b1, 6'd6, 3'd2, 8'h04, 4'h1, 3'd3, 1'b0, 4},
      '{1'b0, 1'b1, 6'd0, 3'd0, 8'hC0, 4'h0, 3'd0, 1'b0, 5}
    };
    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].op, 1'b1);
      chk($sformatf("tbl%0d_out", i), 32'(o1), 32'({tbl[i].stb, tbl[i].sr, tbl[i].al, tbl[i].st, tbl[i].il}));
      chk($sformatf("tbl%0d_retired", i), 32'(retired), tbl[i].ret);
      adv();
    end
    drive(1'b1, 1'b1, 6'd0, 1'b1);
    adv();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b0, 1'b1, 6'd0, 1'b1);
        adv();
      end
      chk($sformatf("cnt2_wrap%0d", k), 32'(retired2), retSeq[k]);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 6'd0, 1'b1);
      adv();
    end
    chk("pre_rst_in_wb", 32'(o1[3:1]), 4);
    drive(1'b1, 1'b1, 6'd0, 1'b1);
    chk("rst_wb_reg_write", 32'(o1[16]), 0);
    chk("rst_wb_retired", 32'(retired), 0);
    chk("rst_wb_retired_cnt2", 32'(retired2), 0);
    adv();
    drive(1'b0, 1'b1, 6'd0, 1'b1);
    chk("post_rst_fetch", 32'({o1[18], o1[3:1]}), 32'({1'b1, 3'd0}));
    adv();
`ifdef MCCU_MEM_WAIT_EN
    drive(1'b1, 1'b1, 6'd4, 1'b1);
    adv();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 6'd4, 1'b1);
      adv();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 6'd4, c == 4);
      chk("memwait_state", 32'(o1[3:1]), 3);
      chk("memwait_mem_read", 32'(o1[15]), 1);
      adv();
    end
    drive(1'b0, 1'b1, 6'd4, 1'b1);
    chk("memwait_wb", 32'(o1[3:1]), 4);
    adv();
`endif
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 6) != 0,
            6'($urandom_range(0, 11)), $urandom_range(0, 9) < 7);
      adv();
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
